// File: rtl/cpu_sys_nios2_qsys_0_oci_pkg.sv
// Shared types for the OCI RAM arbiter: FSM states and grant-owner encoding.
package cpu_sys_nios2_qsys_0_oci_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_J = 2'd1,
        GRANT_C = 2'd2,
        RD_WAIT = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWNER_CPU  = 1'b0,
        OWNER_JTAG = 1'b1
    } grant_owner_t;

endpackage

// File: rtl/cpu_sys_nios2_qsys_0_ocimem_arbiter.sv
// Arbitrates the OCI debug RAM between the JTAG debug path and the CPU debug slave.
// Define OCIMEM_ARB_AUTOINC_EN to post-increment the JTAG address pointer after each JTAG access.
//
// state   | meaning
// --------+-------------------------------------------------------
// IDLE    | no access in flight; arbitrate pending requesters
// GRANT_J | JTAG owns the RAM this cycle (ram_en high)
// GRANT_C | CPU owns the RAM this cycle (ram_en high)
// RD_WAIT | ram_rdata valid; capture it for the read owner
module cpu_sys_nios2_qsys_0_ocimem_arbiter
    import cpu_sys_nios2_qsys_0_oci_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              jtag_rd_req,
    input  logic              jtag_wr_req,
    input  logic              jtag_addr_ld,
    input  logic [ADDR_W-1:0] jtag_addr,
    input  logic [DATA_W-1:0] jtag_wdata,
    output logic [DATA_W-1:0] jtag_rdata,
    output logic              jtag_done,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_en,
    input  logic [DATA_W-1:0] ram_rdata
);

    arb_state_t        state, state_nxt;
    grant_owner_t      last_grant, owner;
    logic              jpend, jwr, cwr;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] avs_rdata_q;
    logic              cpu_req, j_req, j_wr;
    logic              grant_j, grant_c;
    logic              j_complete, c_complete;
    logic              rd_wait_j, rd_wait_c;

    // A fresh pulse counts as pending in the same cycle, so an idle arbiter grants next cycle.
    assign cpu_req   = avs_read | avs_write;
    assign j_req     = jpend | jtag_rd_req | jtag_wr_req;
    assign j_wr      = jpend ? jwr : jtag_wr_req;
    assign rd_wait_j = (state == RD_WAIT) && (owner == OWNER_JTAG);
    assign rd_wait_c = (state == RD_WAIT) && (owner == OWNER_CPU);

    always_comb begin
        state_nxt = state;
        grant_j   = 1'b0;
        grant_c   = 1'b0;
        case (state)
            IDLE: begin
                if (j_req && (!cpu_req || last_grant == OWNER_CPU)) begin
                    grant_j   = 1'b1;
                    state_nxt = GRANT_J;
                end else if (cpu_req) begin
                    grant_c   = 1'b1;
                    state_nxt = GRANT_C;
                end
            end
            GRANT_J: state_nxt = jwr ? IDLE : RD_WAIT;
            GRANT_C: state_nxt = cwr ? IDLE : RD_WAIT;
            RD_WAIT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign j_complete      = ((state == GRANT_J) && jwr) || rd_wait_j;
    assign c_complete      = ((state == GRANT_C) && cwr) || rd_wait_c;
    assign jtag_done       = j_complete;
    assign avs_waitrequest = cpu_req && !c_complete;
    // CPU read data is bypassed straight from the RAM during RD_WAIT, then held.
    assign avs_readdata    = rd_wait_c ? ram_rdata : avs_rdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            last_grant  <= OWNER_CPU;
            owner       <= OWNER_CPU;
            jpend       <= 1'b0;
            jwr         <= 1'b0;
            cwr         <= 1'b0;
            ptr         <= '0;
            jtag_rdata  <= '0;
            avs_rdata_q <= '0;
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
        end else begin
            state  <= state_nxt;
            ram_en <= grant_j | grant_c;
            ram_we <= (grant_j & j_wr) | (grant_c & avs_write);

            if (grant_j) begin
                ram_addr   <= ptr;
                ram_wdata  <= jtag_wdata;
                owner      <= OWNER_JTAG;
                last_grant <= OWNER_JTAG;
            end else if (grant_c) begin
                ram_addr   <= avs_address;
                ram_wdata  <= avs_writedata;
                owner      <= OWNER_CPU;
                last_grant <= OWNER_CPU;
                cwr        <= avs_write;
            end

            if (j_complete) begin
                jpend <= 1'b0;
            end else if (!jpend && (jtag_rd_req || jtag_wr_req)) begin
                jpend <= 1'b1;
                jwr   <= jtag_wr_req;
            end

            if (rd_wait_j) jtag_rdata  <= ram_rdata;
            if (rd_wait_c) avs_rdata_q <= ram_rdata;

            if (jtag_addr_ld) begin
                ptr <= jtag_addr;
`ifdef OCIMEM_ARB_AUTOINC_EN
            end else if (j_complete) begin
                ptr <= ptr + 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_cpu_sys_nios2_qsys_0_ocimem_arbiter.sv
// Self-checking bench for the OCI RAM arbiter with a behavioural RAM and reference memory model.
module tb_cpu_sys_nios2_qsys_0_ocimem_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;
`ifdef OCIMEM_ARB_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          jtag_rd_req = 1'b0, jtag_wr_req = 1'b0, jtag_addr_ld = 1'b0;
    logic [AW-1:0] jtag_addr = '0;
    logic [DW-1:0] jtag_wdata = '0;
    logic [DW-1:0] jtag_rdata;
    logic          jtag_done;
    logic          avs_read = 1'b0, avs_write = 1'b0;
    logic [AW-1:0] avs_address = '0;
    logic [DW-1:0] avs_writedata = '0;
    logic [DW-1:0] avs_readdata;
    logic          avs_waitrequest;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we, ram_en;
    logic [DW-1:0] ram_rdata = '0;

    always #5 clk = ~clk;

    cpu_sys_nios2_qsys_0_ocimem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .jtag_rd_req(jtag_rd_req), .jtag_wr_req(jtag_wr_req), .jtag_addr_ld(jtag_addr_ld),
        .jtag_addr(jtag_addr), .jtag_wdata(jtag_wdata), .jtag_rdata(jtag_rdata), .jtag_done(jtag_done),
        .avs_read(avs_read), .avs_write(avs_write), .avs_address(avs_address),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_en(ram_en),
        .ram_rdata(ram_rdata)
    );

    int n_pass = 0;
    int n_total = 0;

    function automatic logic [31:0] init_val(input int a);
        return 32'(a * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    // External RAM: one-cycle read latency, unwritten words read back as init_val(addr).
    logic [31:0] mem [256];
    bit          mem_valid [256];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr]       <= ram_wdata;
                mem_valid[ram_addr] <= 1'b1;
            end else begin
                ram_rdata <= mem_valid[ram_addr] ? mem[ram_addr] : init_val(int'(ram_addr));
            end
        end
    end

    int            en_cnt = 0, we_cnt = 0, done_cnt = 0;
    logic [AW-1:0] last_addr = '0;
    logic          last_we = 1'b0;
    logic [DW-1:0] last_wdata = '0;
    always @(negedge clk) begin
        if (ram_en) begin
            en_cnt++;
            last_addr  = ram_addr;
            last_we    = ram_we;
            last_wdata = ram_wdata;
            if (ram_we) we_cnt++;
        end
        if (jtag_done) done_cnt++;
    end

    // Reference model: memory contents and where the next JTAG access lands.
    logic [31:0] ref_mem [256];
    int          ref_ptr = 0;

    function automatic int next_ptr(input int p);
        return AUTOINC ? (p + 1) % 256 : p;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        jtag_rd_req = 0; jtag_wr_req = 0; jtag_addr_ld = 0; avs_read = 0; avs_write = 0;
        tick(3);
        reset_n = 1'b1;
        ref_ptr = 0;
        tick(1);
    endtask

    task automatic jtag_load(input logic [AW-1:0] a);
        jtag_addr_ld = 1'b1; jtag_addr = a;
        tick(1);
        jtag_addr_ld = 1'b0;
    endtask

    task automatic jtag_req(input bit wr, input logic [DW-1:0] d);
        jtag_wr_req = wr; jtag_rd_req = !wr; jtag_wdata = d;
        tick(1);
        jtag_wr_req = 1'b0; jtag_rd_req = 1'b0;
    endtask

    task automatic wait_jdone(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (jtag_done) begin ok = 1'b1; break; end
        end
        tick(1);
    endtask

    task automatic cpu_access(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              output bit ok, output logic [DW-1:0] rd);
        ok = 1'b0; rd = '0;
        avs_write = wr; avs_read = !wr; avs_address = a; avs_writedata = d;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!avs_waitrequest) begin ok = 1'b1; rd = avs_readdata; break; end
        end
        tick(1);
        avs_write = 1'b0; avs_read = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(2);
        @(negedge clk);
        n_total++; if (jtag_rdata !== '0) $display("FAIL reset_jtag_rdata: got %h expected 0", jtag_rdata); else n_pass++;
        n_total++; if (jtag_done !== 1'b0) $display("FAIL reset_jtag_done: got %b expected 0", jtag_done); else n_pass++;
        n_total++; if (avs_readdata !== '0) $display("FAIL reset_avs_readdata: got %h expected 0", avs_readdata); else n_pass++;
        n_total++; if ({ram_en, ram_we, ram_addr, ram_wdata} !== '0)
            $display("FAIL reset_ram_outputs: got en=%b we=%b addr=%h wdata=%h expected all 0", ram_en, ram_we, ram_addr, ram_wdata);
        else n_pass++;
        tick(1);
        reset_n = 1'b1;
        ref_ptr = 0;
        tick(1);
    endtask

    task automatic test_jtag_write();
        bit ok; int e0, d0;
        jtag_load(8'h10); ref_ptr = 'h10;
        e0 = en_cnt; d0 = done_cnt;
        jtag_req(1'b1, 32'hDEAD_BEEF);
        wait_jdone(ok);
        n_total++; if (!ok) $display("FAIL jwr_done_timeout: got no jtag_done expected pulse"); else n_pass++;
        n_total++; if ({last_we, last_addr, last_wdata} !== {1'b1, 8'h10, 32'hDEAD_BEEF})
            $display("FAIL jwr_ram: got we=%b addr=%h data=%h expected we=1 addr=10 data=deadbeef", last_we, last_addr, last_wdata);
        else n_pass++;
        ref_mem['h10] = 32'hDEAD_BEEF; ref_ptr = next_ptr(ref_ptr);
        tick(3);
        n_total++; if (done_cnt - d0 !== 1) $display("FAIL jwr_done_count: got %0d expected 1", done_cnt - d0); else n_pass++;
        n_total++; if (en_cnt - e0 !== 1) $display("FAIL jwr_en_count: got %0d expected 1", en_cnt - e0); else n_pass++;
    endtask

    task automatic test_jtag_read();
        bit ok;
        logic [AW-1:0] exp_ptr;
        jtag_load(8'h10); ref_ptr = 'h10;
        jtag_req(1'b0, '0);
        wait_jdone(ok);
        n_total++; if (!ok) $display("FAIL jrd_done_timeout: got no jtag_done expected pulse"); else n_pass++;
        n_total++; if (jtag_rdata !== 32'hDEAD_BEEF) $display("FAIL jrd_rdata: got %h expected deadbeef", jtag_rdata); else n_pass++;
        ref_ptr = next_ptr(ref_ptr);
        exp_ptr = AUTOINC ? 8'h11 : 8'h10;
        jtag_req(1'b1, 32'h1234_5678);
        wait_jdone(ok);
        n_total++; if (last_addr !== exp_ptr) $display("FAIL jrd_ptr_after: got %h expected %h", last_addr, exp_ptr); else n_pass++;
        ref_mem[ref_ptr] = 32'h1234_5678; ref_ptr = next_ptr(ref_ptr);
    endtask

    task automatic test_arbitration();
        logic [AW-1:0] gaddr [$];
        int wl_idx, wl_cnt, jd_idx;
        logic [DW-1:0] rd_seen;
        do_reset();
        wl_idx = -1; wl_cnt = 0; jd_idx = -1; rd_seen = '0;
        avs_read = 1'b1; avs_address = 8'h20; jtag_rd_req = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (ram_en) gaddr.push_back(ram_addr);
            if (jtag_done) jd_idx = i;
            if (avs_read && !avs_waitrequest) begin wl_cnt++; wl_idx = i; rd_seen = avs_readdata; end
            tick(1);
            jtag_rd_req = 1'b0;
            if (wl_idx >= 0) avs_read = 1'b0;
        end
        n_total++; if (gaddr.size() !== 2 || gaddr[0] !== 8'h00 || gaddr[1] !== 8'h20)
            $display("FAIL arb_order: got %0d grants first=%h expected 2 grants 00 then 20", gaddr.size(), (gaddr.size() > 0) ? gaddr[0] : 8'hxx);
        else n_pass++;
        n_total++; if (jd_idx !== 2) $display("FAIL arb_jtag_done_cycle: got %0d expected 2", jd_idx); else n_pass++;
        n_total++; if (wl_cnt !== 1 || wl_idx !== 5)
            $display("FAIL arb_waitrequest: got %0d low cycles at %0d expected 1 at 5", wl_cnt, wl_idx);
        else n_pass++;
        n_total++; if (rd_seen !== ref_mem['h20]) $display("FAIL arb_cpu_rdata: got %h expected %h", rd_seen, ref_mem['h20]); else n_pass++;
        n_total++; if (jtag_rdata !== ref_mem[0]) $display("FAIL arb_jtag_rdata: got %h expected %h", jtag_rdata, ref_mem[0]); else n_pass++;
        ref_ptr = next_ptr(0);
    endtask

    task automatic test_wrap();
        bit ok;
        logic [DW-1:0] d;
        logic [AW-1:0] exp_a;
        jtag_load(8'hFF); ref_ptr = 255;
        d = $urandom;
        jtag_req(1'b1, d); wait_jdone(ok);
        n_total++; if (last_addr !== 8'hFF) $display("FAIL wrap_first_addr: got %h expected ff", last_addr); else n_pass++;
        ref_mem[255] = d; ref_ptr = next_ptr(ref_ptr);
        exp_a = AW'(ref_ptr);
        d = $urandom;
        jtag_req(1'b1, d); wait_jdone(ok);
        n_total++; if (last_addr !== exp_a) $display("FAIL wrap_next_addr: got %h expected %h", last_addr, exp_a); else n_pass++;
        ref_mem[ref_ptr] = d; ref_ptr = next_ptr(ref_ptr);
    endtask

    task automatic test_reset_mid_read();
        int d0, w0, e0;
        jtag_load(8'h30);
        jtag_req(1'b0, '0);
        tick(1);
        d0 = done_cnt; w0 = we_cnt;
        reset_n = 1'b0;
        #1;
        n_total++; if ({jtag_rdata, jtag_done, avs_readdata, ram_en, ram_we, ram_addr, ram_wdata} !== '0)
            $display("FAIL rst_mid_outputs: got rdata=%h done=%b en=%b we=%b addr=%h expected all 0", jtag_rdata, jtag_done, ram_en, ram_we, ram_addr);
        else n_pass++;
        tick(2);
        reset_n = 1'b1;
        ref_ptr = 0;
        e0 = en_cnt;
        tick(10);
        n_total++; if (done_cnt !== d0) $display("FAIL rst_mid_done: got %0d pulses expected 0", done_cnt - d0); else n_pass++;
        n_total++; if (we_cnt !== w0 || en_cnt !== e0)
            $display("FAIL rst_mid_ram_activity: got we=%0d en=%0d expected 0 0", we_cnt - w0, en_cnt - e0);
        else n_pass++;
    endtask

    task automatic test_double_req();
        int e0, d0;
        jtag_load(8'h40);
        e0 = en_cnt; d0 = done_cnt;
        jtag_req(1'b0, '0);
        jtag_req(1'b0, '0);
        tick(10);
        n_total++; if (en_cnt - e0 !== 1) $display("FAIL dbl_accesses: got %0d expected 1", en_cnt - e0); else n_pass++;
        n_total++; if (done_cnt - d0 !== 1) $display("FAIL dbl_done: got %0d expected 1", done_cnt - d0); else n_pass++;
        n_total++; if (jtag_rdata !== ref_mem['h40]) $display("FAIL dbl_rdata: got %h expected %h", jtag_rdata, ref_mem['h40]); else n_pass++;
        ref_ptr = next_ptr('h40);
    endtask

    task automatic test_random();
        bit ok;
        int op;
        logic [AW-1:0] a;
        logic [DW-1:0] d, rd;
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 3);
            d  = $urandom;
            a  = AW'($urandom_range(0, 255));
            if (op < 2) begin
                if ($urandom_range(0, 1) == 1) begin jtag_load(a); ref_ptr = int'(a); end
                jtag_req(op == 0, d);
                wait_jdone(ok);
                n_total++; if (!ok || last_addr !== AW'(ref_ptr))
                    $display("FAIL rnd_jtag_addr: got done=%b addr=%h expected done=1 addr=%h", ok, last_addr, AW'(ref_ptr));
                else n_pass++;
                if (op == 0) begin
                    n_total++; if (last_we !== 1'b1 || last_wdata !== d)
                        $display("FAIL rnd_jtag_wdata: got we=%b data=%h expected we=1 data=%h", last_we, last_wdata, d);
                    else n_pass++;
                    ref_mem[ref_ptr] = d;
                end else begin
                    n_total++; if (jtag_rdata !== ref_mem[ref_ptr])
                        $display("FAIL rnd_jtag_rdata: got %h expected %h", jtag_rdata, ref_mem[ref_ptr]);
                    else n_pass++;
                end
                ref_ptr = next_ptr(ref_ptr);
            end else begin
                cpu_access(op == 2, a, d, ok, rd);
                n_total++; if (!ok || last_addr !== a)
                    $display("FAIL rnd_cpu_addr: got done=%b addr=%h expected done=1 addr=%h", ok, last_addr, a);
                else n_pass++;
                if (op == 2) begin
                    n_total++; if (last_we !== 1'b1 || last_wdata !== d)
                        $display("FAIL rnd_cpu_wdata: got we=%b data=%h expected we=1 data=%h", last_we, last_wdata, d);
                    else n_pass++;
                    ref_mem[a] = d;
                end else begin
                    n_total++; if (rd !== ref_mem[a])
                        $display("FAIL rnd_cpu_rdata: got %h expected %h", rd, ref_mem[a]);
                    else n_pass++;
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        test_reset();
        test_jtag_write();
        test_jtag_read();
        test_arbitration();
        test_wrap();
        test_reset_mid_read();
        test_double_req();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cpu_sys_nios2_qsys_0_ocimem_arbiter.md
CPU_SYS_NIOS2_QSYS_0_OCIMEM_ARBITER -- requirements
Module: cpu_sys_nios2_qsys_0_ocimem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning OCI RAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning OCI RAM data width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset, named clk and reset_n as the codebase does.
REQ-004 SHALL have these ports:
- clk  in  1  system clock.
- reset_n  in  1  async active-low reset.
- jtag_rd_req  in  1  one-cycle pulse; JTAG debug read request.
- jtag_wr_req  in  1  one-cycle pulse; JTAG debug write request.
- jtag_addr_ld  in  1  one-cycle pulse; load jtag_addr into address pointer.
- jtag_addr  in  ADDR_W  JTAG address.
- jtag_wdata  in  DATA_W  JTAG write data.
- jtag_rdata  out  DATA_W  last JTAG read result (MonDReg source).
- jtag_done  out  1  one-cycle pulse; JTAG access complete.
- avs_read  in  1  CPU debug-slave read.
- avs_write  in  1  CPU debug-slave write.
- avs_address  in  ADDR_W  CPU address.
- avs_writedata  in  DATA_W  CPU write data.
- avs_readdata  out  DATA_W  CPU read data.
- avs_waitrequest  out  1  Avalon-MM stall.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_en  out  1  RAM access enable.
- ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after ram_en.

Function
REQ-005 SHALL latch each JTAG request pulse into a pending flag (jpend, jwr) held until serviced.
REQ-006 SHALL ignore a JTAG request pulse while jpend=1; no queueing beyond one.
REQ-007 SHALL implement FSM states IDLE, GRANT_J, GRANT_C, RD_WAIT.
REQ-008 SHALL, in IDLE with only one requester pending, grant it next cycle.
REQ-009 SHALL, with both pending, grant the requester not granted last; last_grant resets to CPU, so JTAG wins first.
REQ-010 SHALL in a grant state drive ram_en=1 for exactly one cycle; ram_we=1 only for writes.
REQ-011 SHALL complete a write in the grant cycle and return to IDLE; a read goes to RD_WAIT, captures ram_rdata, returns to IDLE.
REQ-012 SHALL hold avs_waitrequest=1 while avs_read|avs_write is asserted, except in the completion cycle.
REQ-013 SHALL present CPU read data on avs_readdata in the RD_WAIT cycle; CPU read latency = 2 cycles from grant.
REQ-014 SHALL pulse jtag_done for one cycle on JTAG completion and clear jpend the same cycle.
REQ-015 SHALL update jtag_rdata only on JTAG read completion; hold otherwise.
REQ-016 SHALL give jtag_addr_ld priority over a same-cycle auto-increment.
REQ-017 SHALL wrap the address pointer modulo 2**ADDR_W.
REQ-018 SHALL service a CPU request deasserted mid-wait by not starting it; an access already granted completes.

Reset
REQ-019 SHALL on reset_n=0: state IDLE, jpend/jwr=0, last_grant=CPU, pointer 0, jtag_rdata 0, jtag_done 0, avs_readdata 0, ram_en/ram_we 0, ram_addr/ram_wdata 0.
REQ-020 SHALL abort any in-flight access on reset; no ram_we after reset release until a new grant.

Configuration
REQ-021 SHALL with OCIMEM_ARB_AUTOINC_EN defined, increment the JTAG address pointer by 1 after each JTAG completion.
REQ-022 SHALL without OCIMEM_ARB_AUTOINC_EN, keep the pointer unchanged except on jtag_addr_ld.

Structure
REQ-023 SHALL place the FSM state enum and grant-owner typedef in package cpu_sys_nios2_qsys_0_oci_pkg.
REQ-024 SHALL be a single module with no sub-modules; RAM is external.

Verification
REQ-025 SHALL test: jtag_addr_ld addr=0x10, jtag_wr_req data=0xDEADBEEF -> ram_we=1 at 0x10, jtag_done pulse.
REQ-026 SHALL test: after REQ-025, jtag_rd_req -> jtag_rdata=0xDEADBEEF, ptr=0x11 with macro, 0x10 without.
REQ-027 SHALL test: CPU read and JTAG read same cycle after reset -> JTAG granted first, CPU next; avs_waitrequest low only on CPU completion.
REQ-028 SHALL test: pointer 0xFF, AUTOINC_EN, JTAG write -> pointer 0x00.
REQ-029 SHALL test: reset_n low during RD_WAIT -> all outputs reset values, no jtag_done.
REQ-030 SHALL test: second jtag_rd_req while pending -> exactly one access, one jtag_done.
